// File: rtl/tpu_pkg.sv
// Shared definitions for the training-side update blocks: controller states and Q8.8 format constants.
package tpu_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/gd_issue_pipe.sv
// Two-stage valid/address delay line that tracks each in-flight read through the update unit.
module gd_issue_pipe #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              s1_valid,
  output logic              s2_valid,
  output logic [ADDR_W-1:0] s2_addr
);

  logic [ADDR_W-1:0] s1_addr;

  // Flush drops both stages at once, including a read issued in the flushing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_addr  <= in_addr;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
    end
  end

endmodule

// File: rtl/gd_update_scheduler.sv
// Walks a contiguous parameter block: read value+gradient, hand both to the
// gradient-descent unit, and write the unit's result back to the same address.
module gd_update_scheduler #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] num_values,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              is_bias,
  input  logic [DATA_W-1:0] lr_in,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] value_rdata,
  input  logic [DATA_W-1:0] grad_rdata,
  output logic              gd_valid,
  output logic [DATA_W-1:0] gd_lr,
  output logic [DATA_W-1:0] gd_value_old,
  output logic [DATA_W-1:0] gd_grad,
  output logic              gd_bias_or_weight,
  input  logic [DATA_W-1:0] gd_result,
  input  logic              gd_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        dbg_state
);

  import tpu_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] num_q, cnt_q, addr_q;
  logic [DATA_W-1:0] lr_q;
  logic              bias_q, gap_q;
  logic              issue, accept, flush;
  logic              s1_valid, s2_valid;
  logic [ADDR_W-1:0] s2_addr;

  // Handshake: valid-only, fixed latency. rd_en -> memory data next cycle
  // (gd_valid); gd_valid -> gd_result/gd_done next cycle. No backpressure exists.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          accept  = 1'b1;
          state_d = (num_values == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        issue = !gap_q;
        if (issue && (cnt_q == num_q - ADDR_ONE)) state_d = DRAIN;
      end
      // Stage 2 empties one cycle after stage 1, so leave as soon as stage 1 is empty.
      DRAIN: begin
        if (!s1_valid) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  assign flush = abort && (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      lr_q    <= '0;
      bias_q  <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        num_q  <= num_values;
        cnt_q  <= '0;
        addr_q <= base_addr;
        lr_q   <= lr_in;
        bias_q <= is_bias;
        gap_q  <= 1'b0;
      end else if (issue) begin
        cnt_q  <= cnt_q + ADDR_ONE;
        addr_q <= addr_q + ADDR_ONE;
        // Weight jobs leave a dead cycle so the unit's done flag drops between updates.
        gap_q  <= !bias_q;
      end else begin
        gap_q  <= 1'b0;
      end
    end
  end

  gd_issue_pipe #(
    .ADDR_W(ADDR_W)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (issue),
    .in_addr  (addr_q),
    .s1_valid (s1_valid),
    .s2_valid (s2_valid),
    .s2_addr  (s2_addr)
  );

  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign dbg_state         = state_q;
  assign rd_en             = issue;
  assign rd_addr           = issue ? addr_q : '0;
  assign gd_valid          = s1_valid;
  assign gd_lr             = lr_q;
  assign gd_bias_or_weight = bias_q;
  assign gd_value_old      = s1_valid ? value_rdata : '0;
  assign gd_grad           = s1_valid ? grad_rdata : '0;
  // A stray gd_done with no matching stage-2 entry never reaches memory.
  assign wr_en             = s2_valid && gd_done;
  assign wr_addr           = wr_en ? s2_addr : '0;
  assign wr_data           = wr_en ? gd_result : '0;

endmodule

// File: tb/tb_gd_update_scheduler.sv
// Directed bench for gd_update_scheduler with behavioural memories and a Q8.8 update unit.
module tb_gd_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, is_bias;
  logic [5:0]  num_values, base_addr;
  logic [15:0] lr_in;
  logic        busy, done, rd_en, gd_valid, gd_bias_or_weight, wr_en;
  logic [5:0]  rd_addr, wr_addr;
  logic [15:0] value_rdata, grad_rdata, gd_lr, gd_value_old, gd_grad, gd_result, wr_data;
  logic        gd_done;
  logic [1:0]  dbg_state;

  logic [15:0] value_mem [64];
  logic [15:0] grad_mem  [64];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gd_update_scheduler #(.DATA_W(16), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_values(num_values), .base_addr(base_addr), .is_bias(is_bias), .lr_in(lr_in),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .value_rdata(value_rdata), .grad_rdata(grad_rdata),
    .gd_valid(gd_valid), .gd_lr(gd_lr), .gd_value_old(gd_value_old), .gd_grad(gd_grad),
    .gd_bias_or_weight(gd_bias_or_weight), .gd_result(gd_result), .gd_done(gd_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(dbg_state)
  );

  // Synchronous-read memories and a one-cycle Q8.8 update unit: old - (lr*grad >> 8).
  wire signed [31:0] prod = $signed(gd_lr) * $signed(gd_grad);

  always @(posedge clk) begin
    if (rd_en) begin
      value_rdata <= value_mem[rd_addr];
      grad_rdata  <= grad_mem[rd_addr];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gd_done   <= 1'b0;
      gd_result <= 16'h0000;
    end else begin
      gd_done <= gd_valid;
      if (gd_valid) gd_result <= gd_value_old - prod[23:8];
    end
  end

  task automatic pulse_start(input logic [5:0] n, input logic [5:0] base,
                             input logic bias, input logic [15:0] lr);
    @(negedge clk);
    start = 1'b1; num_values = n; base_addr = base; is_bias = bias; lr_in = lr;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, rd_en, rd_addr, gd_valid, gd_lr, gd_value_old, gd_grad,
         gd_bias_or_weight, wr_en, wr_addr, wr_data, dbg_state} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b rd=%b gdv=%b wr=%b lr=%h st=%0d want all 0",
               busy, done, rd_en, gd_valid, wr_en, gd_lr, dbg_state);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, rd_en, gd_valid, wr_en, dbg_state} !== '0)
      $display("FAIL reset_idle got busy=%b done=%b rd=%b gdv=%b wr=%b st=%0d want 0",
               busy, done, rd_en, gd_valid, wr_en, dbg_state);
    if ({busy, done, rd_en, gd_valid, wr_en, dbg_state} !== '0) errors++;
  endtask

  task automatic test_bias();
    logic [15:0] exp_data [3];
    logic        e_rd, e_wr, e_done, e_busy;
    exp_data[0] = 16'h0080; exp_data[1] = 16'h0180; exp_data[2] = 16'h0280;
    value_mem[4] = 16'h0100; value_mem[5] = 16'h0200; value_mem[6] = 16'h0300;
    grad_mem[4]  = 16'h0100; grad_mem[5]  = 16'h0100; grad_mem[6]  = 16'h0100;
    pulse_start(6'd3, 6'd4, 1'b1, 16'h0080);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      e_rd = (c <= 3); e_wr = (c >= 3 && c <= 5); e_done = (c == 6); e_busy = (c <= 6);
      checks++;
      if ({rd_en, wr_en, done, busy} !== {e_rd, e_wr, e_done, e_busy}) begin
        errors++;
        $display("FAIL bias_ctrl c=%0d got rd/wr/done/busy=%b want %b", c,
                 {rd_en, wr_en, done, busy}, {e_rd, e_wr, e_done, e_busy});
      end
      if (e_rd) begin
        checks++;
        if (rd_addr !== 6'(3 + c)) begin
          errors++;
          $display("FAIL bias_rd_addr c=%0d got=%0d want=%0d", c, rd_addr, 3 + c);
        end
      end
      if (e_wr) begin
        checks++;
        if (wr_addr !== 6'(1 + c) || wr_data !== exp_data[c-3]) begin
          errors++;
          $display("FAIL bias_write c=%0d got addr=%0d data=%h want addr=%0d data=%h",
                   c, wr_addr, wr_data, 1 + c, exp_data[c-3]);
        end
      end
      if (c == 2) begin
        checks++;
        if ({gd_valid, gd_value_old, gd_grad, gd_lr, gd_bias_or_weight, dbg_state} !==
            {1'b1, 16'h0100, 16'h0100, 16'h0080, 1'b1, 2'd1}) begin
          errors++;
          $display("FAIL bias_gd_port got v=%b old=%h grad=%h lr=%h bw=%b st=%0d want 1 0100 0100 0080 1 1",
                   gd_valid, gd_value_old, gd_grad, gd_lr, gd_bias_or_weight, dbg_state);
        end
      end
    end
  endtask

  task automatic test_weight();
    logic e_rd, e_gv, e_wr, e_done, e_busy;
    value_mem[0] = 16'h0400; value_mem[1] = 16'h0500;
    grad_mem[0]  = 16'h0200; grad_mem[1]  = 16'h0200;
    pulse_start(6'd2, 6'd0, 1'b0, 16'h0100);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      e_rd = (c == 1 || c == 3); e_gv = (c == 2 || c == 4); e_wr = (c == 3 || c == 5);
      e_done = (c == 6); e_busy = (c <= 6);
      checks++;
      if ({rd_en, gd_valid, wr_en, done, busy} !== {e_rd, e_gv, e_wr, e_done, e_busy}) begin
        errors++;
        $display("FAIL weight_ctrl c=%0d got rd/gdv/wr/done/busy=%b want %b", c,
                 {rd_en, gd_valid, wr_en, done, busy}, {e_rd, e_gv, e_wr, e_done, e_busy});
      end
      if (e_rd) begin
        checks++;
        if (rd_addr !== 6'((c - 1) / 2)) begin
          errors++;
          $display("FAIL weight_rd_addr c=%0d got=%0d want=%0d", c, rd_addr, (c - 1) / 2);
        end
      end
      if (e_wr) begin
        checks++;
        if (wr_addr !== 6'((c - 3) / 2) || wr_data !== ((c == 3) ? 16'h0200 : 16'h0300)) begin
          errors++;
          $display("FAIL weight_write c=%0d got addr=%0d data=%h want addr=%0d data=%h",
                   c, wr_addr, wr_data, (c - 3) / 2, (c == 3) ? 16'h0200 : 16'h0300);
        end
      end
      if (c == 2) begin
        checks++;
        if (gd_bias_or_weight !== 1'b0) begin
          errors++;
          $display("FAIL weight_flag got=%b want=0", gd_bias_or_weight);
        end
      end
    end
  endtask

  task automatic test_zero();
    pulse_start(6'd0, 6'd9, 1'b1, 16'h0011);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({rd_en, gd_valid, wr_en, done, busy} !== {3'b000, c == 1, c == 1}) begin
        errors++;
        $display("FAIL zero_job c=%0d got rd/gdv/wr/done/busy=%b want %b", c,
                 {rd_en, gd_valid, wr_en, done, busy}, {3'b000, c == 1, c == 1});
      end
    end
  endtask

  task automatic test_wrap();
    logic [5:0]  ea [3];
    logic [15:0] ed [3];
    ea[0] = 6'd62; ea[1] = 6'd63; ea[2] = 6'd0;
    ed[0] = 16'h0010; ed[1] = 16'h0020; ed[2] = 16'h0030;
    for (int i = 0; i < 3; i++) begin
      value_mem[ea[i]] = ed[i];
      grad_mem[ea[i]]  = 16'h0000;
    end
    pulse_start(6'd3, 6'd62, 1'b1, 16'h0100);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== ea[c-1]) begin
          errors++;
          $display("FAIL wrap_rd c=%0d got en=%b addr=%0d want en=1 addr=%0d", c, rd_en, rd_addr, ea[c-1]);
        end
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== ea[c-3] || wr_data !== ed[c-3]) begin
          errors++;
          $display("FAIL wrap_wr c=%0d got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
                   c, wr_en, wr_addr, wr_data, ea[c-3], ed[c-3]);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic exp_ok;
    pulse_start(6'd5, 6'd10, 1'b1, 16'h0000);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_ok = (c <= 2) ? ({rd_en, wr_en, done, busy} === 4'b1001)
                        : ({rd_en, gd_valid, wr_en, done, busy} === 5'b00000);
      checks++;
      if (!exp_ok) begin
        errors++;
        $display("FAIL abort_ctrl c=%0d got rd/gdv/wr/done/busy=%b want %s", c,
                 {rd_en, gd_valid, wr_en, done, busy}, (c <= 2) ? "1x001" : "00000");
      end
      if (c == 2) begin
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
      end
    end
    value_mem[20] = 16'h0700; value_mem[21] = 16'h0800;
    grad_mem[20]  = 16'h0100; grad_mem[21]  = 16'h0100;
    pulse_start(6'd2, 6'd20, 1'b1, 16'h0100);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if ({wr_en, done, busy} !== {c == 3 || c == 4, c == 5, c <= 5}) begin
        errors++;
        $display("FAIL after_abort c=%0d got wr/done/busy=%b want %b", c,
                 {wr_en, done, busy}, {c == 3 || c == 4, c == 5, c <= 5});
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (wr_data !== ((c == 3) ? 16'h0600 : 16'h0700)) begin
          errors++;
          $display("FAIL after_abort_data c=%0d got=%h want=%h", c, wr_data,
                   (c == 3) ? 16'h0600 : 16'h0700);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_rd = 0;
    int n_wr = 0;
    for (int i = 30; i < 34; i++) begin
      value_mem[i] = 16'h1000;
      grad_mem[i]  = 16'h0100;
    end
    pulse_start(6'd4, 6'd30, 1'b1, 16'h0040);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      n_rd += int'(rd_en);
      n_wr += int'(wr_en);
      checks++;
      if ({done, busy} !== {c == 7, c <= 7}) begin
        errors++;
        $display("FAIL b2b_ctrl c=%0d got done/busy=%b want %b", c, {done, busy}, {c == 7, c <= 7});
      end
      if (wr_en) begin
        checks++;
        if (wr_data !== 16'h0FC0) begin
          errors++;
          $display("FAIL b2b_data c=%0d got=%h want=0fc0", c, wr_data);
        end
      end
      if (c == 2 || c == 7) begin
        start = 1'b1; num_values = 6'd1; base_addr = 6'd0; is_bias = 1'b0; lr_in = 16'hFFFF;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    checks++;
    if (n_rd != 4 || n_wr != 4 || gd_lr !== 16'h0040 || gd_bias_or_weight !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ignored_start got rd=%0d wr=%0d lr=%h bw=%b want 4 4 0040 1",
               n_rd, n_wr, gd_lr, gd_bias_or_weight);
    end
  endtask

  task automatic test_async_reset();
    pulse_start(6'd5, 6'd40, 1'b1, 16'h0100);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, rd_en, gd_valid} !== 3'b111) begin
      errors++;
      $display("FAIL arst_pre got busy/rd/gdv=%b want 111", {busy, rd_en, gd_valid});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, rd_en, rd_addr, gd_valid, gd_lr, gd_value_old, gd_grad,
         gd_bias_or_weight, wr_en, wr_addr, wr_data, dbg_state} !== '0) begin
      errors++;
      $display("FAIL arst_outputs got busy=%b rd=%b gdv=%b wr=%b lr=%h bw=%b st=%0d want all 0",
               busy, rd_en, gd_valid, wr_en, gd_lr, gd_bias_or_weight, dbg_state);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, rd_en, gd_valid, wr_en} !== 4'b0000) begin
      errors++;
      $display("FAIL arst_idle got busy/rd/gdv/wr=%b want 0000", {busy, rd_en, gd_valid, wr_en});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    num_values = '0; base_addr = '0; is_bias = 1'b0; lr_in = '0;
    for (int i = 0; i < 64; i++) begin
      value_mem[i] = 16'h0000;
      grad_mem[i]  = 16'h0000;
    end
    test_reset();
    test_bias();
    test_weight();
    test_zero();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
